// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL lock / reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN
  } seq_state_e;

  // Width of one counter able to reach (largest cycle parameter - 1).
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m > 2) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// N-stage single-bit synchroniser for asynchronous status inputs.
// Latency STAGES cycles; no flow control.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_reset_seq.sv
// Resets the PLL, qualifies lock, retries on timeout and releases domain resets in staggered order.
// All outputs registered; no flow control.
module pll_lock_reset_seq
  import pll_seq_pkg::*;
#(
  parameter int SYNC_STAGES         = 2,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 7425000,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int NUM_DOMAINS         = 3,
  parameter int STAGGER_CYCLES      = 64
) (
  input  logic                   refclk,
  input  logic                   rst,
  input  logic                   pll_locked,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic                   ready,
  output logic [7:0]             relock_count,
  output logic                   timeout_err
);

  localparam int CW = cnt_width(LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES,
                                PLL_RST_CYCLES, STAGGER_CYCLES);

  localparam logic [CW-1:0] PLL_RST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] STAGGER_LAST = CW'(STAGGER_CYCLES - 1);

  logic lock_s;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk  (refclk),
    .rst  (rst),
    .din  (pll_locked),
    .dout (lock_s)
  );

  seq_state_e             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   pll_rst_q, pll_rst_d;
  logic [NUM_DOMAINS-1:0] domain_rst_q, domain_rst_d;
  logic                   ready_q, ready_d;
  logic [7:0]             relock_count_q, relock_count_d;
  logic                   timeout_err_q, timeout_err_d;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q + 1'b1;
    pll_rst_d      = pll_rst_q;
    domain_rst_d   = domain_rst_q;
    ready_d        = ready_q;
    relock_count_d = relock_count_q;
    timeout_err_d  = timeout_err_q;

    unique case (state_q)
      PLL_RST: begin
        if (cnt_q == PLL_RST_LAST) begin
          state_d   = WAIT_LOCK;
          cnt_d     = '0;
          pll_rst_d = 1'b0;
        end
      end

      // Lock seen on the timeout cycle still counts as lock.
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d       = PLL_RST;
          cnt_d         = '0;
          pll_rst_d     = 1'b1;
          timeout_err_d = 1'b1;
        end
      end

      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          domain_rst_d = domain_rst_q << 1;
          cnt_d        = '0;
          if (domain_rst_d == '0) begin
            state_d = RUN;
            ready_d = 1'b1;
          end else begin
            state_d = RELEASE;
          end
        end
      end

      // Shifting left clears bits in ascending order; all-zero means the last one went.
      RELEASE, RUN: begin
        if (!lock_s) begin
          state_d      = WAIT_LOCK;
          cnt_d        = '0;
          domain_rst_d = '1;
          ready_d      = 1'b0;
          if (relock_count_q != 8'hFF) begin
            relock_count_d = relock_count_q + 8'd1;
          end
        end else if (state_q == RUN) begin
          cnt_d = cnt_q;
        end else if (cnt_q == STAGGER_LAST) begin
          domain_rst_d = domain_rst_q << 1;
          cnt_d        = '0;
          if (domain_rst_d == '0) begin
            state_d = RUN;
            ready_d = 1'b1;
          end
        end
      end

      default: begin
        state_d      = PLL_RST;
        cnt_d        = '0;
        pll_rst_d    = 1'b1;
        domain_rst_d = '1;
        ready_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q        <= PLL_RST;
      cnt_q          <= '0;
      pll_rst_q      <= 1'b1;
      domain_rst_q   <= '1;
      ready_q        <= 1'b0;
      relock_count_q <= 8'd0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pll_rst_q      <= pll_rst_d;
      domain_rst_q   <= domain_rst_d;
      ready_q        <= ready_d;
      relock_count_q <= relock_count_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign pll_rst      = pll_rst_q;
  assign domain_rst   = domain_rst_q;
  assign ready        = ready_q;
  assign relock_count = relock_count_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Directed bench for pll_lock_reset_seq: timeout retry, qualification, staggered release, relock and saturation.
module tb_pll_lock_reset_seq;

  logic       refclk;
  logic       rst;
  logic       pll_locked;
  logic       pll_rst;
  logic [2:0] domain_rst;
  logic       ready;
  logic [7:0] relock_count;
  logic       timeout_err;

  int checks;
  int errors;

  pll_lock_reset_seq #(
    .SYNC_STAGES         (2),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (32),
    .PLL_RST_CYCLES      (4),
    .NUM_DOMAINS         (3),
    .STAGGER_CYCLES      (2)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .pll_rst      (pll_rst),
    .domain_rst   (domain_rst),
    .ready        (ready),
    .relock_count (relock_count),
    .timeout_err  (timeout_err)
  );

  initial begin
    refclk = 1'b0;
    forever #5 refclk = ~refclk;
  end

  typedef struct {
    int         adv;
    logic       lock;
    logic       pll_rst;
    logic [2:0] dom;
    logic       rdy;
    logic [7:0] rc;
    logic       to;
  } vec_t;

  vec_t vecs[28];

  task automatic step(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_pll, input logic [2:0] e_dom,
                         input logic e_rdy, input logic [7:0] e_rc, input logic e_to);
    chk({tag, ".pll_rst"},      32'(pll_rst),      32'(e_pll));
    chk({tag, ".domain_rst"},   32'(domain_rst),   32'(e_dom));
    chk({tag, ".ready"},        32'(ready),        32'(e_rdy));
    chk({tag, ".relock_count"}, 32'(relock_count), 32'(e_rc));
    chk({tag, ".timeout_err"},  32'(timeout_err),  32'(e_to));
  endtask

  // Returns once domain_rst matches want under mask, or flags a timeout.
  task automatic wait_dom(input string tag, input logic [2:0] mask, input logic [2:0] want,
                          input int bound);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      step(1);
      if ((domain_rst & mask) == want) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s wait actual domain_rst=%0b required=%0b", tag, domain_rst, want);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // adv = edges to advance after applying lock; expectations sampled just after the last edge.
    vecs[0]  = '{3,  1'b0, 1'b1, 3'b111, 1'b0, 8'd0, 1'b0};
    vecs[1]  = '{1,  1'b0, 1'b0, 3'b111, 1'b0, 8'd0, 1'b0};
    vecs[2]  = '{31, 1'b0, 1'b0, 3'b111, 1'b0, 8'd0, 1'b0};
    vecs[3]  = '{1,  1'b0, 1'b1, 3'b111, 1'b0, 8'd0, 1'b1};
    vecs[4]  = '{3,  1'b0, 1'b1, 3'b111, 1'b0, 8'd0, 1'b1};
    vecs[5]  = '{1,  1'b0, 1'b0, 3'b111, 1'b0, 8'd0, 1'b1};
    vecs[6]  = '{31, 1'b0, 1'b0, 3'b111, 1'b0, 8'd0, 1'b1};
    vecs[7]  = '{1,  1'b0, 1'b1, 3'b111, 1'b0, 8'd0, 1'b1};
    vecs[8]  = '{8,  1'b0, 1'b0, 3'b111, 1'b0, 8'd0, 1'b1};
    vecs[9]  = '{10, 1'b1, 1'b0, 3'b111, 1'b0, 8'd0, 1'b1};
    vecs[10] = '{1,  1'b1, 1'b0, 3'b110, 1'b0, 8'd0, 1'b1};
    vecs[11] = '{1,  1'b1, 1'b0, 3'b110, 1'b0, 8'd0, 1'b1};
    vecs[12] = '{1,  1'b1, 1'b0, 3'b100, 1'b0, 8'd0, 1'b1};
    vecs[13] = '{1,  1'b1, 1'b0, 3'b100, 1'b0, 8'd0, 1'b1};
    vecs[14] = '{1,  1'b1, 1'b0, 3'b000, 1'b1, 8'd0, 1'b1};
    vecs[15] = '{5,  1'b1, 1'b0, 3'b000, 1'b1, 8'd0, 1'b1};
    vecs[16] = '{2,  1'b0, 1'b0, 3'b000, 1'b1, 8'd0, 1'b1};
    vecs[17] = '{1,  1'b0, 1'b0, 3'b111, 1'b0, 8'd1, 1'b1};
    vecs[18] = '{10, 1'b1, 1'b0, 3'b111, 1'b0, 8'd1, 1'b1};
    vecs[19] = '{1,  1'b1, 1'b0, 3'b110, 1'b0, 8'd1, 1'b1};
    vecs[20] = '{2,  1'b1, 1'b0, 3'b100, 1'b0, 8'd1, 1'b1};
    vecs[21] = '{2,  1'b1, 1'b0, 3'b000, 1'b1, 8'd1, 1'b1};
    vecs[22] = '{3,  1'b0, 1'b0, 3'b111, 1'b0, 8'd2, 1'b1};
    vecs[23] = '{7,  1'b1, 1'b0, 3'b111, 1'b0, 8'd2, 1'b1};
    vecs[24] = '{1,  1'b0, 1'b0, 3'b111, 1'b0, 8'd2, 1'b1};
    vecs[25] = '{10, 1'b1, 1'b0, 3'b111, 1'b0, 8'd2, 1'b1};
    vecs[26] = '{1,  1'b1, 1'b0, 3'b110, 1'b0, 8'd2, 1'b1};
    vecs[27] = '{4,  1'b1, 1'b0, 3'b000, 1'b1, 8'd2, 1'b1};

    rst        = 1'b1;
    pll_locked = 1'b0;
    step(1);
    chk_all("reset", 1'b1, 3'b111, 1'b0, 8'd0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 28; i++) begin
      pll_locked = vecs[i].lock;
      step(vecs[i].adv);
      chk_all($sformatf("vec%0d", i), vecs[i].pll_rst, vecs[i].dom,
              vecs[i].rdy, vecs[i].rc, vecs[i].to);
    end

    // Lose lock in RUN, relock, then reset while domain_rst is 100.
    pll_locked = 1'b0;
    step(3);
    chk_all("loss3", 1'b0, 3'b111, 1'b0, 8'd3, 1'b1);
    pll_locked = 1'b1;
    step(13);
    chk_all("mid_release", 1'b0, 3'b100, 1'b0, 8'd3, 1'b1);
    rst = 1'b1;
    step(1);
    chk_all("rst_mid_release", 1'b1, 3'b111, 1'b0, 8'd0, 1'b0);
    rst = 1'b0;

    // Repeated lock loss / relock until the counter saturates.
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b1;
      wait_dom($sformatf("sat%0d.release", i), 3'b001, 3'b000, 64);
      pll_locked = 1'b0;
      wait_dom($sformatf("sat%0d.loss", i), 3'b111, 3'b111, 8);
      chk($sformatf("sat%0d.relock_count", i), 32'(relock_count),
          (i + 1 > 255) ? 32'd255 : 32'(i + 1));
      chk($sformatf("sat%0d.pll_rst", i), 32'(pll_rst), 32'd0);
    end
    chk("sat_end.timeout_err", 32'(timeout_err), 32'd0);
    chk("sat_end.ready", 32'(ready), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
